// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALU types: logical-unit opcodes, result-stage state encoding and the
// packed flag bundle produced for each captured result.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Opcode encoding shared with the combinational logical unit.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } alu_op_e;

    // Occupancy of the result stage: no entry, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } stage_state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic parity;
    } alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// -----------------------------------------------------------------------------
// alu_flag_gen
// Combinational flag generator for a logical-unit result.
// Ports:
//   result  in  N            result word
//   flags   out alu_flags_t  {zero, neg (MSB), parity (XOR-reduction)}
// -----------------------------------------------------------------------------
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] result,
    output alu_flags_t   flags
);

    always_comb begin
        flags.zero   = (result == '0);
        flags.neg    = result[N-1];
        flags.parity = ^result;
    end

endmodule

// File: rtl/logic_result_stage.sv
// -----------------------------------------------------------------------------
// logic_result_stage
// Registered output stage behind the logical unit. Captures result, opcode and
// destination index (plus flags) into a 2-entry skid buffer and presents the
// head entry to writeback over valid/ready. in_ready is decoded from the state
// register only, so there is no combinational path from out_ready.
// Configuration macro: ALU_FLAGS_EN -- when defined, flags are generated at
// capture and stored; when undefined, out_zero/out_neg/out_parity are tied 0.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   in_valid/in_ready               upstream handshake
//   in_result, in_op, in_rd         incoming result, opcode, dest index
//   out_valid/out_ready             writeback handshake
//   out_result, out_op, out_rd      head entry fields
//   out_zero, out_neg, out_parity   head entry flags
// -----------------------------------------------------------------------------
module logic_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_result,
    input  logic [1:0]    in_op,
    input  logic [RW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic [1:0]    out_op,
    output logic [RW-1:0] out_rd,
    output logic          out_zero,
    output logic          out_neg,
    output logic          out_parity
);

    stage_state_e state_q, state_d;

    logic [N-1:0]  main_result_q, skid_result_q;
    logic [1:0]    main_op_q, skid_op_q;
    logic [RW-1:0] main_rd_q, skid_rd_q;

    logic accept, drain;
    logic load_main_in, load_main_skid, load_skid;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a drain can change anything.
                if (drain) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= EMPTY;
            main_result_q <= '0;
            main_op_q     <= '0;
            main_rd_q     <= '0;
            skid_result_q <= '0;
            skid_op_q     <= '0;
            skid_rd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_result_q <= in_result;
                main_op_q     <= in_op;
                main_rd_q     <= in_rd;
            end else if (load_main_skid) begin
                main_result_q <= skid_result_q;
                main_op_q     <= skid_op_q;
                main_rd_q     <= skid_rd_q;
            end
            if (load_skid) begin
                skid_result_q <= in_result;
                skid_op_q     <= in_op;
                skid_rd_q     <= in_rd;
            end
        end
    end

    assign out_result = main_result_q;
    assign out_op     = main_op_q;
    assign out_rd     = main_rd_q;

`ifdef ALU_FLAGS_EN
    alu_flags_t in_flags, main_flags_q, skid_flags_q;

    alu_flag_gen #(
        .N(N)
    ) u_flag_gen (
        .result(in_result),
        .flags (in_flags)
    );

    // Flags travel with their entry; never recomputed from output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_flags_q <= '0;
            skid_flags_q <= '0;
        end else begin
            if (load_main_in) begin
                main_flags_q <= in_flags;
            end else if (load_main_skid) begin
                main_flags_q <= skid_flags_q;
            end
            if (load_skid) begin
                skid_flags_q <= in_flags;
            end
        end
    end

    assign out_zero   = main_flags_q.zero;
    assign out_neg    = main_flags_q.neg;
    assign out_parity = main_flags_q.parity;
`else
    assign out_zero   = 1'b0;
    assign out_neg    = 1'b0;
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_result_stage.sv
// -----------------------------------------------------------------------------
// tb_logic_result_stage
// Self-checking bench for logic_result_stage: vector table, directed
// backpressure/streaming/reset sequences, and a randomized run against a
// capacity-2 FIFO reference model.
// -----------------------------------------------------------------------------
module tb_logic_result_stage;

    localparam int N  = 32;
    localparam int RW = 5;
`ifdef ALU_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_result = '0;
    logic [1:0]    in_op = '0;
    logic [RW-1:0] in_rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_result;
    logic [1:0]    out_op;
    logic [RW-1:0] out_rd;
    logic          out_zero, out_neg, out_parity;

    logic_result_stage #(
        .N (N),
        .RW(RW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_op    (out_op),
        .out_rd    (out_rd),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_parity(out_parity)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0]  result;
        logic [1:0]    op;
        logic [RW-1:0] rd;
        logic          zero;
        logic          neg;
        logic          parity;
    } vec_t;

    typedef struct {
        logic [N-1:0]  result;
        logic [1:0]    op;
        logic [RW-1:0] rd;
    } entry_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input entry_t e);
        logic z, n, p;
        z = FlagsEn & (e.result == 0);
        n = FlagsEn & e.result[N-1];
        p = FlagsEn & (^e.result);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, out_result, e.result);
        chk({tag, ".op"}, 32'(out_op), 32'(e.op));
        chk({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
        chk({tag, ".zero"}, 32'(out_zero), 32'(z));
        chk({tag, ".neg"}, 32'(out_neg), 32'(n));
        chk({tag, ".parity"}, 32'(out_parity), 32'(p));
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [1:0] op, input logic [RW-1:0] rd);
        in_valid  = 1'b1;
        in_result = r;
        in_op     = op;
        in_rd     = rd;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    vec_t   vecs[6];
    entry_t e;
    entry_t q[$];
    bit     hold;
    bit     acc, drn;

    initial begin
        // Hand-computed flags for a spread of results.
        vecs[0] = '{32'h0000_0000, 2'b00, 5'd3,  1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h8000_0001, 2'b11, 5'd7,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0001, 2'b01, 5'd31, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 2'b10, 5'd0,  1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0007, 2'b01, 5'd12, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h8000_0000, 2'b11, 5'd20, 1'b0, 1'b1, 1'b1};

        // Reset state
        #2;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_result", out_result, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Table-driven single transfers
        foreach (vecs[i]) begin
            out_ready = 1'b0;
            drive(vecs[i].result, vecs[i].op, vecs[i].rd);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d.result", i), out_result, vecs[i].result);
            chk($sformatf("vec%0d.op", i), 32'(out_op), 32'(vecs[i].op));
            chk($sformatf("vec%0d.rd", i), 32'(out_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d.zero", i), 32'(out_zero), 32'(FlagsEn & vecs[i].zero));
            chk($sformatf("vec%0d.neg", i), 32'(out_neg), 32'(FlagsEn & vecs[i].neg));
            chk($sformatf("vec%0d.parity", i), 32'(out_parity), 32'(FlagsEn & vecs[i].parity));
            out_ready = 1'b1;
            tick();
            chk($sformatf("vec%0d.drained", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: A, B fill the stage, C must wait
        out_ready = 1'b0;
        drive(32'hA, 2'b00, 5'd1);
        tick();
        drive(32'hB, 2'b01, 5'd2);
        tick();
        chk("bp.in_ready_low", 32'(in_ready), 32'd0);
        chk("bp.head_a", out_result, 32'hA);
        drive(32'hC, 2'b10, 5'd3);
        tick();
        chk("bp.in_ready_still_low", 32'(in_ready), 32'd0);
        chk("bp.head_a_stable", out_result, 32'hA);
        chk("bp.rd_a_stable", 32'(out_rd), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp.head_b", out_result, 32'hB);
        chk("bp.valid_b", 32'(out_valid), 32'd1);
        chk("bp.in_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp.head_c", out_result, 32'hC);
        chk("bp.valid_c", 32'(out_valid), 32'd1);
        chk("bp.rd_c", 32'(out_rd), 32'd3);
        tick();
        chk("bp.empty", 32'(out_valid), 32'd0);

        // Streaming 0..99 with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(32'(i), 2'(i), 5'(i));
            tick();
            chk($sformatf("stream%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d.result", i), out_result, 32'(i));
            chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream.empty", 32'(out_valid), 32'd0);

        // Simultaneous accept and drain in ONE
        out_ready = 1'b0;
        drive(32'h5, 2'b00, 5'd5);
        tick();
        chk("sim.head5", out_result, 32'h5);
        out_ready = 1'b1;
        drive(32'h6, 2'b01, 5'd6);
        tick();
        in_valid = 1'b0;
        chk("sim.head6", out_result, 32'h6);
        chk("sim.valid", 32'(out_valid), 32'd1);
        chk("sim.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("sim.empty", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        drive(32'h11, 2'b00, 5'd1);
        tick();
        drive(32'h22, 2'b00, 5'd2);
        tick();
        in_valid = 1'b0;
        chk("rmid.full", 32'(in_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmid.out_valid", 32'(out_valid), 32'd0);
        chk("rmid.in_ready", 32'(in_ready), 32'd1);
        chk("rmid.result_cleared", out_result, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        drive(32'h77, 2'b10, 5'd9);
        tick();
        in_valid = 1'b0;
        e = '{32'h77, 2'b10, 5'd9};
        chk_head("rmid.first", e);
        out_ready = 1'b1;
        tick();
        chk("rmid.no_stale", 32'(out_valid), 32'd0);

        // Randomized traffic against a capacity-2 FIFO model
        do_reset();
        q.delete();
        hold = 1'b0;
        for (int c = 0; c < 500; c++) begin
            chk($sformatf("rnd%0d.valid", c), 32'(out_valid), 32'(q.size() != 0));
            chk($sformatf("rnd%0d.in_ready", c), 32'(in_ready), 32'(q.size() < 2));
            if (q.size() != 0) chk_head($sformatf("rnd%0d", c), q[0]);
            // Upstream keeps a rejected item stable until accepted.
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       in_result = '0;
                    1:       in_result = 32'h8000_0000 | $urandom;
                    default: in_result = $urandom;
                endcase
                in_op = 2'($urandom);
                in_rd = 5'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            acc  = in_valid && (q.size() < 2);
            drn  = out_ready && (q.size() > 0);
            hold = in_valid && !acc;
            e    = '{in_result, in_op, in_rd};
            tick();
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
